decryption_core: RTL and testbench
==================================

Name: decryption_core

Overview:
- Iterative AES inverse cipher (FIPS-197 §5.3): one decryption round per clock, consuming the expanded key schedule produced by the team's keyExpansion block.
- Counterpart of the encryption core. It sits between keyExpansion and the SPI subnode inside the future decryption unit: ciphertext in from the subnode, plaintext back to it.
- Supports AES-128/192/256 through parameters.

Parameters:
- nk, 4, key length in 32-bit words (4, 6 or 8).
- nb, 4, state columns; fixed at 4 for AES; other values unsupported.
- nr, 10, number of rounds (10, 12 or 14, matching nk).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  start request; sampled on rising clk.
- cipher  input  32*nb  ciphertext block; byte 0 at [127:120]; column-major state order.
- w  input  32*nb*(nr+1)  expanded key; word w[0] at the MSBs, w[i] at [32*nb*(nr+1)-1-32*i -: 32].
- msg  output  32*nb  recovered plaintext; same byte order as cipher.
- out_valid  output  1  one-cycle pulse: msg is newly valid.
- busy  output  1  high while a block is in flight.

Behaviour:
- Reset values (rst high at an edge): msg=0, out_valid=0, busy=0, FSM=IDLE, round counter=0, state register=0.
- FSM states: IDLE, ROUND.
- IDLE:
  - in_valid=1 at an edge is the acceptance edge T0.
  - At T0: state <= cipher XOR roundkey(nr), where roundkey(r) = w[4r..4r+3]; counter <= nr-1; busy <= 1; FSM -> ROUND.
  - in_valid=0: remain in IDLE.
- ROUND (each edge):
  - state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), roundkey(counter)), followed by InvMixColumns when counter != 0.
  - counter decrements.
  - When counter == 0, the result is written to msg instead of state. At that edge: out_valid <= 1, busy <= 0, FSM -> IDLE.
- Latency: out_valid is high in the cycle after edge T0+nr (AES-128: 10 edges after acceptance).
- out_valid is high for exactly one cycle. msg holds its value until the next completion or reset.
- in_valid while busy=1 is ignored. No queuing, no error flag.
- Back-to-back operation: in_valid during the out_valid cycle is accepted, because the FSM is already IDLE. Throughput is one block per nr+1 cycles.
- rst mid-operation aborts the block with no out_valid, and all registers return to reset values. rst has priority over in_valid at the same edge.
- Inverse S-box: internal 256-entry lookup function; 16 instances, combinational.
- InvMixColumns: GF(2^8) multiply by 0e/0b/0d/09 using xtime chains, polynomial 0x11b.
- Without the optional feature, w must be held stable from T0 through the completion edge. Cipher is sampled only at T0.
- Per-round critical path: one round of logic plus the round-key mux.

Optional Feature:
- Macro: DEC_KEY_LATCH_EN.
- Defined: an internal key register of 32*nb*(nr+1) bits captures w at T0, and all rounds read this register. The caller may change w after T0, e.g. when keyExpansion starts on the next key. The register is cleared by rst.
- Undefined: no key register; rounds read w directly, so w must be stable for the whole operation. This saves about 1408 flops (AES-128).
- Latency and the port list are identical in both builds.

Test Plan:
- AES-128, key 000102030405060708090a0b0c0d0e0f expanded into w, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, in_valid pulse -> out_valid exactly 11 edges later, msg=00112233445566778899aabbccddeeff.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> msg=3243f6a8885a308d313198a2e0370734.
- nk=6/nr=12 build, key 000102...1617, cipher dda97ca4864cdfe06eaf70a0ec0d7191 -> msg=00112233445566778899aabbccddeeff after 13 edges. nk=8/nr=14 build, key 000102...1e1f, cipher 8ea2b7ca516745bfeafc49904b496089 -> same msg after 15 edges.
- in_valid held high continuously with two vectors alternated at each acceptance -> out_valid every 11 cycles with correct msg each time. Changing cipher mid-block has no effect.
- rst asserted 5 cycles after acceptance -> busy=0, msg=0, no out_valid. A new in_valid the cycle after rst deasserts completes normally.
- With DEC_KEY_LATCH_EN defined: w overwritten with all zeros 1 cycle after T0 -> msg is still correct. Without the macro, the same stimulus -> msg differs, which confirms w is read live.

Source files
------------

// File: rtl/decryption_core.sv
// decryption_core: iterative AES inverse cipher, one round per clock.
// Takes an expanded key schedule from keyExpansion and a ciphertext block,
// returns the recovered plaintext nr+1 cycles after acceptance.
//
// Parameters: nk (key words 4/6/8), nb (state columns, must be 4),
//             nr (rounds 10/12/14, must equal nk+6).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   in_valid       - start request, accepted only while idle
//   cipher         - ciphertext block, byte 0 at the MSBs
//   w              - expanded key, word w[0] at the MSBs
//   msg            - plaintext, held until the next completion or reset
//   out_valid      - one-cycle completion pulse
//   busy           - a block is in flight
// Build option: DEC_KEY_LATCH_EN captures w at acceptance into an internal
// key register so the caller may change w while a block is in flight.
module decryption_core #(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [32*nb-1:0]        cipher,
    input  logic [32*nb*(nr+1)-1:0] w,
    output logic [32*nb-1:0]        msg,
    output logic                    out_valid,
    output logic                    busy
);
    localparam int SW = 32 * nb;
    localparam int KW = SW * (nr + 1);
    localparam int CW = $clog2(nr + 1);

    if (nb != 4 || nr != nk + 6) begin : g_bad_cfg
        $error("decryption_core: unsupported nk/nb/nr combination");
    end

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic {IDLE, ROUND} fsm_e;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k is a constant at every call site, so this folds to an XOR network
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // One inverse round; byte r+4c of the block is state row r, column c.
    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         mix);
        logic [127:0] sr, sb, ak, r;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                sr[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c-rr+4)%4)) -: 8];
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]);
        ak = sb ^ rk;
        r  = ak;
        if (mix)
            for (int c = 0; c < 4; c++)
                r[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
        return r;
    endfunction

    fsm_e          fsm_q, fsm_d;
    logic [SW-1:0] st_q, st_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [SW-1:0] msg_q, msg_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [KW-1:0] key_src;

`ifdef DEC_KEY_LATCH_EN
    logic [KW-1:0] key_q, key_d;
    assign key_src = key_q;
`else
    assign key_src = w;
`endif

    // Packed view of the schedule: element r is roundkey(r), element 0 at the MSBs
    logic [0:nr][SW-1:0] rk_arr;
    logic [SW-1:0]       rk;
    logic [SW-1:0]       round_out;

    assign rk_arr    = key_src;
    assign rk        = rk_arr[ctr_q];
    assign round_out = inv_round(st_q, rk, ctr_q != '0);

    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        ctr_d       = ctr_q;
        msg_d       = msg_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
`ifdef DEC_KEY_LATCH_EN
        key_d       = key_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    // Initial whitening always uses live w: the key register
                    // only loads at this same edge.
                    st_d   = cipher ^ w[SW-1:0];
                    ctr_d  = CW'(nr - 1);
                    busy_d = 1'b1;
                    fsm_d  = ROUND;
`ifdef DEC_KEY_LATCH_EN
                    key_d  = w;
`endif
                end
            end
            ROUND: begin
                ctr_d = ctr_q - CW'(1);
                if (ctr_q == '0) begin
                    msg_d       = round_out;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    fsm_d       = IDLE;
                end else begin
                    st_d = round_out;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            ctr_q       <= '0;
            msg_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DEC_KEY_LATCH_EN
            key_q       <= '0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            ctr_q       <= ctr_d;
            msg_q       <= msg_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef DEC_KEY_LATCH_EN
            key_q       <= key_d;
`endif
        end
    end

    assign msg       = msg_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_decryption_core.sv
// Self-checking bench for decryption_core: AES-128/192/256 instances,
// FIPS-197 known-answer vectors, back-to-back operation, abort by reset,
// and live-w versus latched-key behaviour.
module tb_decryption_core;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [191:0] K3 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] C3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K4 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C4 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           iv [3];
    logic [127:0]   ct [3];
    logic [127:0]   ms [3];
    logic           ov [3];
    logic           bz [3];
    logic [1407:0]  w128;
    logic [1663:0]  w192;
    logic [1919:0]  w256;
    logic [1407:0]  wk1, wk2;
    logic [127:0]   exp_q [$];
    int             n_assert = 0;
    int             n_fail   = 0;

    always #5 clk = ~clk;

    decryption_core #(.nk(4), .nb(4), .nr(10)) dut128 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .cipher(ct[0]), .w(w128),
        .msg(ms[0]), .out_valid(ov[0]), .busy(bz[0]));
    decryption_core #(.nk(6), .nb(4), .nr(12)) dut192 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .cipher(ct[1]), .w(w192),
        .msg(ms[1]), .out_valid(ov[1]), .busy(bz[1]));
    decryption_core #(.nk(8), .nb(4), .nr(14)) dut256 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .cipher(ct[2]), .w(w256),
        .msg(ms[2]), .out_valid(ov[2]), .busy(bz[2]));

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    // FIPS-197 key expansion; key and result are MSB-aligned, w[0] first
    function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nkk);
        logic [31:0]   wa [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int            nw;
        nw = 4 * (nkk + 7);
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < nkk; i++) wa[i] = key[255-32*i -: 32];
        for (int i = nkk; i < nw; i++) begin
            t = wa[i-1];
            if (i % nkk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nkk > 6 && i % nkk == 4) begin
                t = subw(t);
            end
            wa[i] = wa[i-nkk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[1919-32*i -: 32] = wa[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until out_valid is seen (bounded); n = edges since acceptance
    task automatic wait_done(input int d, input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ov[d] !== 1'b1 && n < 40);
        chk({tag, " out_valid seen"}, 128'(ov[d]), 128'd1);
    endtask

    task automatic check_msg(input int d, input string tag);
        logic [127:0] e;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, " msg"}, ms[d], e);
    endtask

    task automatic run_one(input int d, input logic [127:0] c, input logic [127:0] p,
                           input int lat, input string tag);
        int n;
        ct[d] = c;
        iv[d] = 1'b1;
        exp_q.push_back(p);
        tick();
        iv[d] = 1'b0;
        chk({tag, " busy"}, 128'(bz[d]), 128'd1);
        wait_done(d, tag, n);
        chk({tag, " latency"}, 128'(n), 128'(lat));
        check_msg(d, tag);
        tick();
        chk({tag, " pulse"}, 128'(ov[d]), 128'd0);
        chk({tag, " idle"}, 128'(bz[d]), 128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1919:0] wf;
        logic [127:0]  cts [2];
        logic [127:0]  pts [2];
        logic [1407:0] wvs [2];
        int            n;
        int            sel;

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            ct[d] = '0;
        end
        wf   = key_expand({K1, 128'h0}, 4); wk1 = wf[1919 -: 1408];
        wf   = key_expand({K2, 128'h0}, 4); wk2 = wf[1919 -: 1408];
        wf   = key_expand({K3, 64'h0}, 6);  w192 = wf[1919 -: 1664];
        w256 = key_expand(K4, 8);
        w128 = wk1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset msg", ms[0], '0);
        chk("reset out_valid", 128'(ov[0]), 128'd0);
        chk("reset busy", 128'(bz[0]), 128'd0);
        rst = 1'b0;
        tick();

        // Known-answer vectors
        run_one(0, C1, P1, 10, "aes128 kat1");
        w128 = wk2;
        run_one(0, C2, P2, 10, "aes128 kat2");
        run_one(1, C3, P1, 12, "aes192 kat");
        run_one(2, C4, P1, 14, "aes256 kat");

        // Back-to-back with in_valid held high; cipher scrambled mid-block
        cts[0] = C1; pts[0] = P1; wvs[0] = wk1;
        cts[1] = C2; pts[1] = P2; wvs[1] = wk2;
        w128  = wvs[0];
        ct[0] = cts[0];
        iv[0] = 1'b1;
        exp_q.push_back(pts[0]);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b2b busy", 128'(bz[0]), 128'd1);
            ct[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            wait_done(0, "b2b", n);
            chk("b2b period", 128'(n), 128'd10);
            check_msg(0, "b2b");
            if (k < 3) begin
                sel   = (k + 1) % 2;
                w128  = wvs[sel];
                ct[0] = cts[sel];
                exp_q.push_back(pts[sel]);
            end else begin
                iv[0] = 1'b0;
            end
        end
        tick();
        chk("b2b end idle", 128'(bz[0]), 128'd0);

        // Abort by reset on the 5th edge after acceptance, with in_valid also high
        w128  = wk1;
        ct[0] = C1;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();
        rst   = 1'b1;
        iv[0] = 1'b1;
        tick();
        rst   = 1'b0;
        iv[0] = 1'b0;
        chk("abort busy", 128'(bz[0]), 128'd0);
        chk("abort msg", ms[0], '0);
        chk("abort out_valid", 128'(ov[0]), 128'd0);
        run_one(0, C2 ^ C2 ^ C1, P1, 10, "after abort");

        // Key overwritten one cycle after acceptance
        w128  = wk1;
        ct[0] = C1;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        w128  = '0;
        wait_done(0, "key hold", n);
        chk("key hold latency", 128'(n), 128'd10);
`ifdef DEC_KEY_LATCH_EN
        chk("latched key msg", ms[0], P1);
`else
        n_assert++;
        assert (ms[0] !== P1) else begin
            n_fail++;
            $error("FAIL live key msg: observed %h expected any value other than %h", ms[0], P1);
        end
`endif
        w128 = wk1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
